// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative multiplier family.
// Operands are widened to MAX_W so one abs helper serves every width up to 32.
package mul_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // value must already be sign-extended to MAX_W when signed_en is set.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                               input logic             signed_en);
        logic [MAX_W-1:0] res;
        res = value;
        if (signed_en && value[MAX_W-1]) begin
            res = ~value + MAX_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_digit_step.sv
// One radix-2^DIGIT step: accumulate a_mag * digit, weighted by the step position.
// DIGIT-row partial-product array reduced by an adder chain, then shifted into place.
module mul_digit_step #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic [2*WIDTH-1:0]                                       acc,
    input  logic [WIDTH-1:0]                                         a_mag,
    input  logic [DIGIT-1:0]                                         digit,
    input  logic [((WIDTH/DIGIT) > 1 ? $clog2(WIDTH/DIGIT) : 1)-1:0] count,
    output logic [2*WIDTH-1:0]                                       acc_next
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] pp [DIGIT];
    logic [PW-1:0] pp_sum;

    always_comb begin
        for (int r = 0; r < DIGIT; r++) begin
            pp[r] = digit[r] ? ({{WIDTH{1'b0}}, a_mag} << r) : '0;
        end
        pp_sum = '0;
        for (int r = 0; r < DIGIT; r++) begin
            pp_sum = pp_sum + pp[r];
        end
        // Total product is < 2^PW, so this sum can never carry out.
        acc_next = acc + (pp_sum << (int'(count) * DIGIT));
    end

endmodule

// File: rtl/seq_booth_free_mul.sv
// Iterative sign-magnitude multiplier retiring DIGIT multiplier bits per cycle.
// Fixed latency of WIDTH/DIGIT cycles from accept to out_valid; WIDTH must be <= 32.
module seq_booth_free_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               busy
);

    localparam int unsigned K  = WIDTH / DIGIT;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             valid_q, valid_d;

    logic [MAX_W-1:0] a_ext, b_ext;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [PW-1:0]    acc_next;

    // Sign-extend only for signed ops so unsigned operands with MSB set pass unchanged.
    always_comb begin
        a_ext = {{(MAX_W-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
        b_ext = {{(MAX_W-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
        a_abs = WIDTH'(abs_w(a_ext, in_signed));
        b_abs = WIDTH'(abs_w(b_ext, in_signed));
    end

    mul_digit_step #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_step (
        .acc      (acc_q),
        .a_mag    (a_q),
        .digit    (b_q[DIGIT-1:0]),
        .count    (cnt_q),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_abs;
                    b_d     = b_abs;
                    neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_next;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    prod_d  = neg_q ? (~acc_next + PW'(1)) : acc_next;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = valid_q;
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_seq_booth_free_mul.sv
// Self-checking bench: W=8/D=2, W=4/D=1 and W=16/D=4 instances against an integer model.
module tb_seq_booth_free_mul;

    logic clk = 1'b0;
    logic rst;
    logic ordy;
    always #5 clk = ~clk;

    logic iv8, ir8, ov8, sg8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic iv4, ir4, ov4, sg4, bz4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic iv16, ir16, ov16, sg16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int tests = 0;
    int fails = 0;

    seq_booth_free_mul #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_signed(sg8), .out_valid(ov8), .out_ready(ordy), .out_prod(p8), .busy(bz8)
    );
    seq_booth_free_mul #(.WIDTH(4), .DIGIT(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_signed(sg4), .out_valid(ov4), .out_ready(ordy), .out_prod(p4), .busy(bz4)
    );
    seq_booth_free_mul #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_signed(sg16), .out_valid(ov16), .out_ready(ordy), .out_prod(p16), .busy(bz16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Golden product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sg);
        longint m;
        longint va;
        longint vb;
        longint p;
        m  = longint'(1) << w;
        va = longint'(a) % m;
        vb = longint'(b) % m;
        if (sg && va >= m / 2) va = va - m;
        if (sg && vb >= m / 2) vb = vb - m;
        p = (va * vb) & ((m * m) - 1);
        return p[31:0];
    endfunction

    function automatic logic ov_of(input int w);
        case (w)
            4:       return ov4;
            16:      return ov16;
            default: return ov8;
        endcase
    endfunction

    function automatic logic ir_of(input int w);
        case (w)
            4:       return ir4;
            16:      return ir16;
            default: return ir8;
        endcase
    endfunction

    function automatic logic [31:0] prod_of(input int w);
        case (w)
            4:       return {24'h0, p4};
            16:      return p16;
            default: return {16'h0, p8};
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic sg);
        case (w)
            4:       begin iv4 = v;  a4 = a[3:0];  b4 = b[3:0];  sg4 = sg;  end
            16:      begin iv16 = v; a16 = a;      b16 = b;      sg16 = sg; end
            default: begin iv8 = v;  a8 = a[7:0];  b8 = b[7:0];  sg8 = sg;  end
        endcase
    endtask

    // One full transaction: accept, measure latency, compare, then consume.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic sg, input logic [31:0] exp, input string tag);
        int t;
        int lat;
        t   = 0;
        lat = 0;
        @(negedge clk);
        while (!ir_of(w) && t < 20) begin
            @(negedge clk);
            t++;
        end
        drive(w, 1'b1, a, b, sg);
        @(posedge clk);
        #1;
        drive(w, 1'b0, a, b, sg);
        while (!ov_of(w) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_prod"}, prod_of(w), exp);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [31:0] q[$];
        logic [31:0] exp;
        int          last_ov;
        int          n_acc;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[3] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        vecs[7] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vecs[9] = '{8'hF0, 8'h03, 1'b0, 16'h02D0};

        ordy = 1'b0;
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ov8, 0);
        check("rst_out_prod", p8, 0);
        check("rst_in_ready", ir8, 0);
        check("rst_busy", bz8, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", ir8, 1);

        for (int i = 0; i < 10; i++) begin
            run_op(8, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].sg,
                   {16'h0, vecs[i].prod}, $sformatf("vec%0d", i));
        end

        // Backpressure with ignored in_valid pulses.
        @(negedge clk);
        drive(8, 1'b1, 16'h0A, 16'h0B, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid_rise", ov8, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(8, i[0], 16'h55, 16'h77, 1'b1);
            @(posedge clk);
            #1;
            check("bp_valid_held", ov8, 1);
            check("bp_prod_held", p8, 32'h6E);
            check("bp_in_ready_low", ir8, 0);
        end
        @(negedge clk);
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        check("bp_valid_drop", ov8, 0);
        check("bp_prod_retained", p8, 32'h6E);
        check("bp_busy_clear", bz8, 0);
        run_op(8, 16'h03, 16'h05, 1'b0, 32'h0F, "bp_next");

        // Abort in the middle of an operation.
        @(negedge clk);
        drive(8, 1'b1, 16'hFF, 16'hFF, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_valid", ov8, 0);
        check("abort_prod", p8, 0);
        check("abort_in_ready", ir8, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rel_in_ready", ir8, 1);
        check("abort_rel_busy", bz8, 0);
        check("abort_rel_prod", p8, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_late_valid", ov8, 0);
        run_op(8, 16'h12, 16'h34, 1'b0, 32'h03A8, "abort_next");

        // Exhaustive W=4, D=1.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ra = 16'(a);
                    rb = 16'(b);
                    rs = (s == 1);
                    run_op(4, ra, rb, rs, ref_mul(4, ra, rb, rs), "w4");
                end
            end
        end

        // Random W=16, D=4 plus corners.
        run_op(16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_min_min");
        run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "w16_max_u");
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'(i % 2);
            run_op(16, ra, rb, rs, ref_mul(16, ra, rb, rs), "w16_rand");
        end

        // Streaming: in_valid and out_ready held high.
        last_ov = -1;
        n_acc   = 0;
        ordy    = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c < 60) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom);
                drive(8, 1'b1, ra, rb, rs);
            end else begin
                drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
            end
            if (iv8 && ir8) begin
                q.push_back(ref_mul(8, ra, rb, rs));
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (ov8) begin
                if (last_ov >= 0) check("tput_gap", c - last_ov, 6);
                last_ov = c;
                exp = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                check("tput_prod", p8, exp);
            end
        end
        ordy = 1'b0;
        check("tput_accepts", n_acc, 10);
        check("tput_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
